fetch_seq_ins: RTL and testbench
================================

// Module: fetch_seq_ins
// PURPOSE
//  Byte-serial Y86-64 instruction fetch for the SEQ processor; the producer side of the execute stage.
//  Reads one byte per memory handshake, splits it into icode/ifun/rA/rB/valC and computes valP.
//  Presents one decoded instruction per valid/ready handshake to decode/execute.
// PARAMETERS
//  RESET_PC  64'd0  address fetched automatically on the first cycle after reset release
// PORTS
//  clk           in   1   single clock, all state updates on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  pc_wr         in   1   start a fetch at pc_in (new PC from writeback/PC-update)
//  pc_in         in   64  fetch address qualified by pc_wr
//  imem_req      out  1   byte read request; held with imem_addr stable until imem_ack
//  imem_addr     out  64  byte address of the current request
//  imem_ack      in   1   read complete; imem_data/imem_err valid this cycle
//  imem_data     in   8   returned byte
//  imem_err      in   1   address error, qualified by imem_ack
//  out_valid     out  1   decoded instruction fields are valid and held
//  out_ready     in   1   consumer accepts the instruction when out_valid && out_ready
//  icode         out  4   byte0[7:4]
//  ifun          out  4   byte0[3:0]
//  rA            out  4   byte1[7:4]; 4'hF when no register byte
//  rB            out  4   byte1[3:0]; 4'hF when no register byte
//  valC          out  64  little-endian constant, 64'd0 when absent
//  valP          out  64  address of the next sequential instruction
//  instr_valid   out  1   0 when icode > 4'hB
//  mem_error     out  1   1 if any byte of this instruction returned imem_err
// BEHAVIOUR
//  Reset (async, rst_n=0): state=OPC, pc=RESET_PC, imem_req=0, out_valid=0, all field outputs 0,
//   rA=rB=4'hF, instr_valid=1, mem_error=0. Fetch of RESET_PC starts on the first clock edge after rst_n rises.
//  States: IDLE -> OPC -> [REG] -> [CST x8] -> HOLD -> IDLE.
//  IDLE: imem_req=0; pc_wr=1 -> pc<=pc_in and go to OPC.
//  OPC/REG/CST: imem_req=1; imem_addr=pc+byte_idx. A byte is consumed on each edge with imem_ack=1.
//   With imem_ack=0, hold the state and address (unbounded wait).
//  OPC byte: icode/ifun latched. Length rules follow from icode:
//   need_reg for {2,3,4,5,6,A,B}
//   need_valC for {3,4,5,7,8}
//   1-byte for {0,1,9} and for invalid icode (C..F, instr_valid=0)
//  CST: byte k (k=0..7) is written to valC[8k+7:8k]; a 3-bit counter wraps 7 -> done.
//  valP = pc + 1 + need_reg + 8*need_valC (64-bit, wraps modulo 2^64), valid from HOLD.
//  imem_err with imem_ack on any byte: mem_error<=1, abort the remaining bytes, go to HOLD.
//   Fields not yet read keep their defaults.
//  HOLD: out_valid=1; all field outputs stable until accepted.
//   Accept (out_ready=1): out_valid=0 next cycle, go to IDLE.
//   pc_wr=1 on the accept cycle: go directly to OPC at pc_in.
//  pc_wr outside IDLE/HOLD-accept is ignored. halt (icode 0) is presented like any 1-byte instruction;
//   stopping is the controller's decision.
//  Latency with zero-wait memory (ack in the request cycle): an N-byte instruction raises out_valid
//   N cycles after entering OPC.
//  Asserting rst_n mid-fetch discards partial fields immediately; fetch restarts at RESET_PC.
// TESTING
//  Zero-wait memory, pc_in=0x100, bytes 30 F3 0A 00..00 -> icode=3, rB=3, valC=10, valP=0x10A, out_valid after 10 cycles.
//  Bytes 60 12 at 0x20 with out_ready low for 5 cycles -> icode=6, rA=1, rB=2, valP=0x22; fields stable until accept.
//  Bytes 80 + 8-byte 0x0000000000000400 at 0x0 -> valC=0x400, rA=rB=F, valP=0x9.
//  Byte 0xC0 -> instr_valid=0, valP=pc+1. Byte 0x90 -> ret, valP=pc+1. Both with mem_error=0.
//  imem_err on 3rd byte of irmovq -> mem_error=1, out_valid next cycle, no further imem_req.
//  imem_ack delayed 3 cycles per byte, plus rst_n pulse mid-valC -> outputs at reset values, refetch at RESET_PC.

Source files
------------

// File: rtl/fetch_seq_ins.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ins
// Purpose  : Byte-serial Y86-64 instruction fetch for the SEQ processor.
//            Reads one byte per memory handshake, splits it into
//            icode/ifun/rA/rB/valC, computes valP and hands one decoded
//            instruction per valid/ready handshake to decode/execute.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq_ins #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wr,
  input  logic [63:0] pc_in,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  input  logic        imem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        mem_error
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_OPC  = 3'd1;
  localparam logic [2:0] c_REG  = 3'd2;
  localparam logic [2:0] c_CST  = 3'd3;
  localparam logic [2:0] c_HOLD = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [63:0] r_pc;
  logic [3:0]  r_idx;        // byte offset of the current request from r_pc
  logic [2:0]  r_cst;        // constant byte counter, wraps 7 -> done
  logic        r_armed;      // low only until the first edge after reset release
  logic        r_need_valc;
  logic [3:0]  r_icode;
  logic [3:0]  r_ifun;
  logic [3:0]  r_ra;
  logic [3:0]  r_rb;
  logic [63:0] r_valc;
  logic [63:0] r_valp;
  logic        r_instr_valid;
  logic        r_mem_error;

  logic        w_take;
  logic        w_start;
  logic        w_op_need_reg;
  logic        w_op_need_valc;
  logic [63:0] w_op_valp;

  function automatic logic f_need_reg(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic f_need_valc(input logic [3:0] ic);
    case (ic)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Opcode-byte decode straight from the returned data, used in the OPC cycle
  assign w_op_need_reg  = f_need_reg(imem_data[7:4]);
  assign w_op_need_valc = f_need_valc(imem_data[7:4]);
  assign w_op_valp      = r_pc + 64'd1 + {63'd0, w_op_need_reg}
                        + {60'd0, w_op_need_valc, 3'b000};

  assign w_take  = imem_req & imem_ack;
  assign w_start = pc_wr & ((r_state == c_IDLE) | ((r_state == c_HOLD) & out_ready));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_OPC;
    else        r_state <= w_next_state;
  end

  // Next-state logic: byte sequencing, error abort and output handshake
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (pc_wr) w_next_state = c_OPC;
      c_OPC: if (w_take) begin
        if (imem_err)            w_next_state = c_HOLD;
        else if (w_op_need_reg)  w_next_state = c_REG;
        else if (w_op_need_valc) w_next_state = c_CST;
        else                     w_next_state = c_HOLD;
      end
      c_REG: if (w_take) begin
        if (imem_err)         w_next_state = c_HOLD;
        else if (r_need_valc) w_next_state = c_CST;
        else                  w_next_state = c_HOLD;
      end
      c_CST: if (w_take) begin
        if (imem_err || (r_cst == 3'd7)) w_next_state = c_HOLD;
      end
      c_HOLD: if (out_ready) w_next_state = pc_wr ? c_OPC : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output logic: memory request while fetching, valid while holding
  always_comb begin
    imem_req  = 1'b0;
    out_valid = 1'b0;
    imem_addr = r_pc + {60'd0, r_idx};
    case (r_state)
      c_OPC, c_REG, c_CST: imem_req  = r_armed;
      c_HOLD:              out_valid = 1'b1;
      default:             ;
    endcase
  end

  // Datapath: PC capture, byte counters and decoded field registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_idx         <= 4'd0;
      r_cst         <= 3'd0;
      r_armed       <= 1'b0;
      r_need_valc   <= 1'b0;
      r_icode       <= 4'h0;
      r_ifun        <= 4'h0;
      r_ra          <= 4'hF;
      r_rb          <= 4'hF;
      r_valc        <= 64'd0;
      r_valp        <= 64'd0;
      r_instr_valid <= 1'b1;
      r_mem_error   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_start) begin
        r_pc          <= pc_in;
        r_idx         <= 4'd0;
        r_cst         <= 3'd0;
        r_need_valc   <= 1'b0;
        r_icode       <= 4'h0;
        r_ifun        <= 4'h0;
        r_ra          <= 4'hF;
        r_rb          <= 4'hF;
        r_valc        <= 64'd0;
        r_valp        <= 64'd0;
        r_instr_valid <= 1'b1;
        r_mem_error   <= 1'b0;
      end else if (w_take) begin
        r_idx <= r_idx + 4'd1;
        if (imem_err) begin
          r_mem_error <= 1'b1;
        end else begin
          case (r_state)
            c_OPC: begin
              r_icode       <= imem_data[7:4];
              r_ifun        <= imem_data[3:0];
              r_instr_valid <= (imem_data[7:4] <= 4'hB);
              r_need_valc   <= w_op_need_valc;
              r_valp        <= w_op_valp;
            end
            c_REG: begin
              r_ra <= imem_data[7:4];
              r_rb <= imem_data[3:0];
            end
            c_CST: begin
              r_valc[{r_cst, 3'b000} +: 8] <= imem_data;
              r_cst                        <= r_cst + 3'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign icode       = r_icode;
  assign ifun        = r_ifun;
  assign rA          = r_ra;
  assign rB          = r_rb;
  assign valC        = r_valc;
  assign valP        = r_valp;
  assign instr_valid = r_instr_valid;
  assign mem_error   = r_mem_error;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq_ins.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq_ins
// Purpose  : Self-checking bench for fetch_seq_ins. A byte memory with
//            configurable wait states and an error address feeds the DUT;
//            an instruction-level model predicts the presented fields.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq_ins;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_wr;
  logic [63:0] pc_in;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [7:0]  imem_data;
  logic        imem_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        instr_valid, mem_error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] exp_pc;
  logic        err_en;
  logic [63:0] err_addr;
  int          delay;
  int          wait_cnt;
  int          cycles;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic        iv;
    logic        me;
  } exp_t;

  fetch_seq_ins #(.RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_wr(pc_wr), .pc_in(pc_in),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic is_err(input logic [63:0] a);
    return err_en && (err_addr == a);
  endfunction

  // Instruction-level prediction: length from icode, fields from memory bytes,
  // fetch stops at the first erroring byte leaving later fields at defaults
  function automatic exp_t model(input logic [63:0] pc);
    exp_t        e;
    logic [7:0]  b;
    logic [63:0] a;
    int          nr, nv;
    e      = '0;
    e.ra   = 4'hF;
    e.rb   = 4'hF;
    e.iv   = 1'b1;
    if (is_err(pc)) begin
      e.me = 1'b1;
      return e;
    end
    b       = rd(pc);
    e.icode = b[7:4];
    e.ifun  = b[3:0];
    e.iv    = (b[7:4] <= 4'hB);
    nr      = (b[7:4] inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
    nv      = (b[7:4] inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
    e.valp  = pc + 64'(1 + nr + 8 * nv);
    if (nr == 1) begin
      if (is_err(pc + 64'd1)) begin
        e.me = 1'b1;
        return e;
      end
      b    = rd(pc + 64'd1);
      e.ra = b[7:4];
      e.rb = b[3:0];
    end
    if (nv == 1) begin
      for (int k = 0; k < 8; k++) begin
        a = pc + 64'(1 + nr + k);
        if (is_err(a)) begin
          e.me = 1'b1;
          return e;
        end
        e.valc[8*k +: 8] = rd(a);
      end
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: acknowledges after 'delay' idle negedges per byte
  initial begin
    imem_ack  = 1'b0;
    imem_data = 8'hEE;
    imem_err  = 1'b0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_err  = 1'b0;
      imem_data = 8'hEE;
      if (rst_n && imem_req) begin
        if (wait_cnt >= delay) begin
          imem_ack  = 1'b1;
          imem_data = rd(imem_addr);
          imem_err  = is_err(imem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Compare process: every cycle an instruction is presented
  initial begin
    exp_t ce;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        ce = model(exp_pc);
        chk("icode",       64'(icode),       64'(ce.icode));
        chk("ifun",        64'(ifun),        64'(ce.ifun));
        chk("rA",          64'(rA),          64'(ce.ra));
        chk("rB",          64'(rB),          64'(ce.rb));
        chk("valC",        valC,             ce.valc);
        chk("valP",        valP,             ce.valp);
        chk("instr_valid", 64'(instr_valid), 64'(ce.iv));
        chk("mem_error",   64'(mem_error),   64'(ce.me));
        chk("req_in_hold", 64'(imem_req),    64'd0);
      end
    end
  end

  task automatic wait_valid();
    cycles = 0;
    while (!out_valid && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic start(input logic [63:0] pc);
    pc_wr = 1'b1;
    pc_in = pc;
    @(negedge clk);
    pc_wr  = 1'b0;
    exp_pc = pc;
  endtask

  task automatic accept(input logic wr, input logic [63:0] pc);
    out_ready = 1'b1;
    pc_wr     = wr;
    pc_in     = pc;
    @(negedge clk);
    out_ready = 1'b0;
    pc_wr     = 1'b0;
    chk("accept_drop", 64'(out_valid), 64'd0);
    if (wr) exp_pc = pc;
  endtask

  task automatic put(input logic [63:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    pc_wr     = 1'b0;
    pc_in     = 64'd0;
    out_ready = 1'b0;
    err_en    = 1'b0;
    err_addr  = 64'd0;
    delay     = 0;
    exp_pc    = 64'd0;

    // call 0x400 at 0x0
    put(64'h0, 8'h80); put(64'h1, 8'h00); put(64'h2, 8'h04);
    for (int i = 3; i < 9; i++) put(64'(i), 8'h00);
    // irmovq $10, %rbx at 0x100
    put(64'h100, 8'h30); put(64'h101, 8'hF3); put(64'h102, 8'h0A);
    for (int i = 3; i < 10; i++) put(64'h100 + 64'(i), 8'h00);
    // addq %rcx, %rdx at 0x20
    put(64'h20, 8'h60); put(64'h21, 8'h12);
    put(64'h30, 8'hC0);                          // invalid
    put(64'h40, 8'h90);                          // ret
    put(64'hFFFF_FFFF_FFFF_FFFF, 8'h10);         // nop at top of memory
    // irmovq at 0x50 (error on third byte) and 0x60 (slow memory)
    put(64'h50, 8'h30); put(64'h51, 8'hF2);
    for (int i = 2; i < 10; i++) put(64'h50 + 64'(i), 8'h55);
    put(64'h60, 8'h30); put(64'h61, 8'hF4);
    for (int i = 2; i < 10; i++) put(64'h60 + 64'(i), 8'(8'h11 * (i - 1)));

    repeat (2) @(negedge clk);
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_imem_req",    64'(imem_req),    64'd0);
    chk("rst_icode",       64'(icode),       64'd0);
    chk("rst_rA",          64'(rA),          64'hF);
    chk("rst_rB",          64'(rB),          64'hF);
    chk("rst_valC",        valC,             64'd0);
    chk("rst_valP",        valP,             64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd1);
    chk("rst_mem_error",   64'(mem_error),   64'd0);

    // Automatic fetch of RESET_PC
    rst_n = 1'b1;
    wait_valid();
    chk("call_icode", 64'(icode), 64'h8);
    chk("call_valC",  valC,       64'h400);
    chk("call_rA",    64'(rA),    64'hF);
    chk("call_valP",  valP,       64'h9);
    accept(1'b0, 64'd0);

    // 10-byte irmovq, zero-wait latency
    start(64'h100);
    wait_valid();
    chk("irmov_latency", 64'(cycles), 64'd10);
    chk("irmov_icode",   64'(icode),  64'h3);
    chk("irmov_rB",      64'(rB),     64'h3);
    chk("irmov_valC",    valC,        64'd10);
    chk("irmov_valP",    valP,        64'h10A);
    accept(1'b1, 64'h20);

    // OPq, consumer stalls for 5 cycles
    wait_valid();
    chk("opq_latency", 64'(cycles), 64'd2);
    repeat (5) @(negedge clk);
    chk("opq_held_valid", 64'(out_valid), 64'd1);
    chk("opq_icode",      64'(icode),     64'h6);
    chk("opq_rA",         64'(rA),        64'h1);
    chk("opq_rB",         64'(rB),        64'h2);
    chk("opq_valP",       valP,           64'h22);
    accept(1'b0, 64'd0);

    // Invalid icode
    start(64'h30);
    wait_valid();
    chk("inv_latency",     64'(cycles),      64'd1);
    chk("inv_instr_valid", 64'(instr_valid), 64'd0);
    chk("inv_valP",        valP,             64'h31);
    chk("inv_mem_error",   64'(mem_error),   64'd0);
    accept(1'b1, 64'h40);

    // ret
    wait_valid();
    chk("ret_icode", 64'(icode), 64'h9);
    chk("ret_valP",  valP,       64'h41);
    accept(1'b0, 64'd0);

    // valP wraps modulo 2^64
    start(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid();
    chk("wrap_valP", valP, 64'd0);
    accept(1'b0, 64'd0);

    // Memory error on third byte of irmovq
    err_en   = 1'b1;
    err_addr = 64'h52;
    start(64'h50);
    wait_valid();
    chk("err_latency",   64'(cycles),    64'd3);
    chk("err_mem_error", 64'(mem_error), 64'd1);
    chk("err_valC",      valC,           64'd0);
    repeat (3) @(negedge clk);
    chk("err_no_req", 64'(imem_req), 64'd0);
    accept(1'b0, 64'd0);
    err_en = 1'b0;

    // Slow memory, reset pulse in the middle of valC
    delay = 3;
    start(64'h60);
    repeat (20) @(negedge clk);
    chk("slow_not_done", 64'(out_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_imem_req",  64'(imem_req),  64'd0);
    chk("midrst_valC",      valC,           64'd0);
    chk("midrst_rB",        64'(rB),        64'hF);
    chk("midrst_icode",     64'(icode),     64'd0);
    exp_pc = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid();
    chk("refetch_icode", 64'(icode), 64'h8);
    chk("refetch_valC",  valC,       64'h400);
    chk("refetch_valP",  valP,       64'h9);
    accept(1'b0, 64'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
